corr_search_sequencer: RTL and testbench
========================================

Name: corr_search_sequencer

Overview:
- Sequences the correlation engine over a rectangular search window (ROI) once per captured frame.
- Issues one start pulse per (X,Y) candidate, waits for the engine's result, and tracks the arg-max.
- Reports the best coordinate and score with a done pulse.
- Sits between the frame-capture logic (frame-done) and the correlation datapath; the result feeds the tracking/overlay logic.

Parameters:
- COORD_W, 13, width of X/Y coordinates and ROI bounds
- CORR_W, 24, width of the unsigned correlation score
- STEP, 1, scan stride in both X and Y (>=1)

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset, synchronous, active-high
- iFrameDone  in  1  level; a rising edge requests a new search
- iAbort  in  1  cancels an in-progress search
- iXmin, iXmax, iYmin, iYmax  in  COORD_W each  ROI bounds, inclusive; latched at search start
- oCorrStart  out  1  one-cycle pulse; engine evaluates at oX/oY
- oX, oY  out  COORD_W each  current candidate coordinate; stable from oCorrStart until iCorrValid
- iCorrValid  in  1  engine result strobe
- iCorrValue  in  CORR_W  engine score, unsigned
- oBusy  out  1  high in any state except IDLE
- oDone  out  1  one-cycle pulse at search completion
- oResultValid  out  1  high when oXresult/oYresult/oBestCorr hold a valid result
- oXresult, oYresult  out  COORD_W each  arg-max coordinate
- oBestCorr  out  CORR_W  maximum score found

Behaviour:
- Reset values: all outputs 0; state IDLE; edge-detect register 0.
- Start condition: rising edge of iFrameDone in IDLE. A level held high does not retrigger. Edges seen outside IDLE are ignored.
- Start actions (one cycle):
  - latch ROI
  - X=Xmin, Y=Ymin
  - clear best and oResultValid; set first-flag
  - go to CHECK
- CHECK:
  - if Xmin>Xmax or Ymin>Ymax: go to DONE with oResultValid=0
  - else go to ISSUE
- ISSUE: oCorrStart=1 for exactly this cycle; next state WAIT.
- WAIT: hold until iCorrValid. On the valid cycle:
  - Update best when first-flag is set or iCorrValue > best (strict; a tie keeps the earlier scan position). Clear first-flag on update.
  - Advance X first:
    - if X+STEP <= Xmax: X += STEP
    - else if Y+STEP <= Ymax: X = Xmin, Y += STEP
    - else: go to DONE
  - Otherwise go to ISSUE.
  - Sums are computed at COORD_W+1 bits, so the counters never wrap.
- Throughput: with engine latency L (valid at cycle t+L after oCorrStart at t, L>=1), the next oCorrStart is at t+L+1.
- iCorrValid outside WAIT: ignored.
- DONE:
  - oDone=1 for one cycle
  - oResultValid=1 if at least one candidate was evaluated
  - go to IDLE
  - result outputs hold until the next start
- iAbort, in any non-IDLE state: go to IDLE next cycle, no oDone, oResultValid=0. iAbort in IDLE has no effect. iAbort together with iCorrValid: abort wins.
- iRST mid-search: everything returns to reset values on the next edge.
- Scan order: raster (X fastest). oBestCorr only changes in WAIT.

Decomposition:
- Package corr_pkg holds:
  - COORD_W, CORR_W defaults
  - the state enum IDLE/CHECK/ISSUE/WAIT/DONE
  - a coord_t typedef
- One sub-module, corr_argmax_tracker: clear/update inputs, strict-greater compare, holds best score and coordinate.

Test Plan:
- ROI X 0..1, Y 0..1, STEP 1, L=3, scores 5,9,9,2 → four oCorrStart pulses at cycles t, t+4, t+8, t+12; oDone; result (1,0), best 9 (tie keeps first).
- ROI X 3..8, Y 0..0, STEP 2 → oX sequence 3,5,7 then done (9 > 8). Exactly three starts.
- iFrameDone held high for 100 cycles after a search finishes → no second search. A low→high edge starts the next one.
- Invalid ROI (Xmin=10, Xmax=4) → no oCorrStart; oDone after 2 cycles; oResultValid=0.
- iAbort asserted in WAIT on the same cycle as iCorrValid with a score exceeding best → IDLE, oDone never pulses, oResultValid=0, oBestCorr unchanged.
- iRST asserted during the second candidate → all outputs 0 next cycle. A fresh frame-done edge then runs a full correct search.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared widths, FSM state encoding and coordinate type for the correlation
// search sequencer.
package corr_pkg;

  localparam int COORD_W_DEFAULT = 13;
  localparam int CORR_W_DEFAULT  = 24;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

endpackage

// File: rtl/corr_argmax_tracker.sv
// Running arg-max of engine scores. A tie keeps the earlier candidate; the
// first update after a clear is always taken, whatever its score.
module corr_argmax_tracker #(
  parameter int COORD_W = 13,
  parameter int CORR_W  = 24
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iClear,
  input  logic               iUpdate,
  input  logic [CORR_W-1:0]  iValue,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  output logic [CORR_W-1:0]  oBest,
  output logic [COORD_W-1:0] oXbest,
  output logic [COORD_W-1:0] oYbest
);

  logic               first_q, first_d;
  logic [CORR_W-1:0]  best_q, best_d;
  logic [COORD_W-1:0] xbest_q, xbest_d;
  logic [COORD_W-1:0] ybest_q, ybest_d;

  always_comb begin
    first_d = first_q;
    best_d  = best_q;
    xbest_d = xbest_q;
    ybest_d = ybest_q;
    if (iClear) begin
      first_d = 1'b1;
      best_d  = '0;
      xbest_d = '0;
      ybest_d = '0;
    end else if (iUpdate && (first_q || (iValue > best_q))) begin
      first_d = 1'b0;
      best_d  = iValue;
      xbest_d = iX;
      ybest_d = iY;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      first_q <= 1'b0;
      best_q  <= '0;
      xbest_q <= '0;
      ybest_q <= '0;
    end else begin
      first_q <= first_d;
      best_q  <= best_d;
      xbest_q <= xbest_d;
      ybest_q <= ybest_d;
    end
  end

  assign oBest  = best_q;
  assign oXbest = xbest_q;
  assign oYbest = ybest_q;

endmodule

// File: rtl/corr_search_sequencer.sv
// Walks the ROI in raster order once per frame-done edge, issuing one engine
// start per candidate and reporting the arg-max with a done pulse.
module corr_search_sequencer
  import corr_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int CORR_W  = CORR_W_DEFAULT,
  parameter int STEP    = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFrameDone,
  input  logic               iAbort,
  input  logic [COORD_W-1:0] iXmin,
  input  logic [COORD_W-1:0] iXmax,
  input  logic [COORD_W-1:0] iYmin,
  input  logic [COORD_W-1:0] iYmax,
  output logic               oCorrStart,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  input  logic               iCorrValid,
  input  logic [CORR_W-1:0]  iCorrValue,
  output logic               oBusy,
  output logic               oDone,
  output logic               oResultValid,
  output logic [COORD_W-1:0] oXresult,
  output logic [COORD_W-1:0] oYresult,
  output logic [CORR_W-1:0]  oBestCorr
);

  localparam logic [COORD_W:0] STEP_EXT = (COORD_W+1)'(STEP);

  state_t             state_q, state_d;
  logic               fd_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               rvalid_q, rvalid_d;
  logic               busy_q, busy_d;
  logic               trk_clear, trk_update;
  logic               fd_rise;
  logic [COORD_W:0]   x_inc, y_inc;

  assign fd_rise = iFrameDone & ~fd_q;
  // One extra bit so a step past the top of the coordinate range never wraps.
  assign x_inc   = {1'b0, x_q} + STEP_EXT;
  assign y_inc   = {1'b0, y_q} + STEP_EXT;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    rvalid_d   = rvalid_q;
    trk_clear  = 1'b0;
    trk_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (fd_rise) begin
          xmin_d    = iXmin;
          xmax_d    = iXmax;
          ymin_d    = iYmin;
          ymax_d    = iYmax;
          x_d       = iXmin;
          y_d       = iYmin;
          rvalid_d  = 1'b0;
          trk_clear = 1'b1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if ((xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ISSUE;
          start_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (iCorrValid) begin
          trk_update = 1'b1;
          if (x_inc <= {1'b0, xmax_q}) begin
            x_d     = x_inc[COORD_W-1:0];
            state_d = ISSUE;
            start_d = 1'b1;
          end else if (y_inc <= {1'b0, ymax_q}) begin
            x_d     = xmin_q;
            y_d     = y_inc[COORD_W-1:0];
            state_d = ISSUE;
            start_d = 1'b1;
          end else begin
            // Reaching DONE from WAIT implies at least one evaluated candidate.
            state_d  = DONE;
            done_d   = 1'b1;
            rvalid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (iAbort && (state_q != IDLE)) begin
      state_d    = IDLE;
      x_d        = x_q;
      y_d        = y_q;
      start_d    = 1'b0;
      done_d     = 1'b0;
      rvalid_d   = 1'b0;
      trk_update = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      fd_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fd_q     <= iFrameDone;
      x_q      <= x_d;
      y_q      <= y_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      start_q  <= start_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
    end
  end

  corr_argmax_tracker #(
    .COORD_W (COORD_W),
    .CORR_W  (CORR_W)
  ) u_tracker (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iClear  (trk_clear),
    .iUpdate (trk_update),
    .iValue  (iCorrValue),
    .iX      (x_q),
    .iY      (y_q),
    .oBest   (oBestCorr),
    .oXbest  (oXresult),
    .oYbest  (oYresult)
  );

  assign oCorrStart   = start_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oResultValid = rvalid_q;

endmodule

// File: tb/tb_corr_search_sequencer.sv
// Bench for corr_search_sequencer: table of ROI/latency/score vectors with a
// raster-order reference model, plus abort, reset, hold and stride sequences.
module tb_corr_search_sequencer;

  localparam int CW = 13;
  localparam int VW = 24;

  logic          iCLK = 1'b0;
  logic          iRST, iFrameDone, iAbort, iCorrValid;
  logic [CW-1:0] iXmin, iXmax, iYmin, iYmax;
  logic [VW-1:0] iCorrValue;
  logic          oCorrStart, oBusy, oDone, oResultValid;
  logic [CW-1:0] oX, oY, oXresult, oYresult;
  logic [VW-1:0] oBestCorr;

  logic          d2_fd, d2_abort, d2_valid;
  logic [CW-1:0] d2_xmin, d2_xmax, d2_ymin, d2_ymax;
  logic [VW-1:0] d2_value;
  logic          d2_start, d2_busy, d2_done, d2_rvalid;
  logic [CW-1:0] d2_x, d2_y, d2_xres, d2_yres;
  logic [VW-1:0] d2_best;

  always #5 iCLK = ~iCLK;

  corr_search_sequencer #(.COORD_W(CW), .CORR_W(VW), .STEP(1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFrameDone(iFrameDone), .iAbort(iAbort),
    .iXmin(iXmin), .iXmax(iXmax), .iYmin(iYmin), .iYmax(iYmax),
    .oCorrStart(oCorrStart), .oX(oX), .oY(oY),
    .iCorrValid(iCorrValid), .iCorrValue(iCorrValue),
    .oBusy(oBusy), .oDone(oDone), .oResultValid(oResultValid),
    .oXresult(oXresult), .oYresult(oYresult), .oBestCorr(oBestCorr));

  corr_search_sequencer #(.COORD_W(CW), .CORR_W(VW), .STEP(2)) dut_s2 (
    .iCLK(iCLK), .iRST(iRST), .iFrameDone(d2_fd), .iAbort(d2_abort),
    .iXmin(d2_xmin), .iXmax(d2_xmax), .iYmin(d2_ymin), .iYmax(d2_ymax),
    .oCorrStart(d2_start), .oX(d2_x), .oY(d2_y),
    .iCorrValid(d2_valid), .iCorrValue(d2_value),
    .oBusy(d2_busy), .oDone(d2_done), .oResultValid(d2_rvalid),
    .oXresult(d2_xres), .oYresult(d2_yres), .oBestCorr(d2_best));

  typedef struct {
    logic [CW-1:0] xmin, xmax, ymin, ymax;
    int            lat;
  } vec_t;

  typedef struct packed {
    logic [CW-1:0] x, y;
  } xy_t;

  vec_t          vt [7];
  logic [VW-1:0] sc_tab [7][8];
  xy_t           exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic step();
    @(negedge iCLK);
    iCorrValid = 1'b0;
    iCorrValue = '0;
    iAbort     = 1'b0;
  endtask

  task automatic kick(input logic [CW-1:0] xa, input logic [CW-1:0] xb,
                      input logic [CW-1:0] ya, input logic [CW-1:0] yb);
    step();
    iFrameDone = 1'b0;
    iXmin = xa; iXmax = xb; iYmin = ya; iYmax = yb;
    step();
    iFrameDone = 1'b1;
  endtask

  task automatic wait_start(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      if (oCorrStart) ok = 1'b1;
    end
    if (!ok) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_vec(input int v);
    int            n, cyc, vcnt, starts, last, cidx, dcnt, dcyc, lastv, lat;
    bit            has;
    logic [VW-1:0] s, ebest;
    logic [CW-1:0] ex, ey;
    xy_t           e;
    lat = vt[v].lat;
    exp_q.delete();
    n = 0; has = 1'b0; ebest = '0; ex = '0; ey = '0;
    if (vt[v].xmin <= vt[v].xmax && vt[v].ymin <= vt[v].ymax)
      for (int y = int'(vt[v].ymin); y <= int'(vt[v].ymax); y++)
        for (int x = int'(vt[v].xmin); x <= int'(vt[v].xmax); x++) begin
          exp_q.push_back({x[CW-1:0], y[CW-1:0]});
          s = sc_tab[v][n % 8];
          if (!has || s > ebest) begin
            has = 1'b1; ebest = s; ex = x[CW-1:0]; ey = y[CW-1:0];
          end
          n++;
        end

    kick(vt[v].xmin, vt[v].xmax, vt[v].ymin, vt[v].ymax);
    cyc = 0; vcnt = 0; starts = 0; last = 0; cidx = 0; dcnt = 0; dcyc = 0; lastv = 0;
    while (cyc < 2000 && dcnt == 0) begin
      step();
      cyc++;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          iCorrValid = 1'b1;
          iCorrValue = sc_tab[v][cidx % 8];
          cidx++;
          lastv = cyc;
        end
      end
      if (oCorrStart) begin
        starts++;
        if (exp_q.size() == 0) chk("extra_start", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("start_xy", {oX, oY}, {e.x, e.y});
        end
        if (starts == 1) chk("first_start_cyc", cyc, 2);
        else             chk("start_gap", cyc - last, lat + 1);
        last = cyc;
        vcnt = lat;
      end
      if (oDone) begin
        dcnt++;
        dcyc = cyc;
        chk("busy_at_done", oBusy, 1);
        chk("rvalid", oResultValid, (n > 0));
        if (n > 0) begin
          chk("done_latency", dcyc, lastv + 1);
          chk("result_xy", {oXresult, oYresult}, {ex, ey});
          chk("best", oBestCorr, ebest);
        end else begin
          chk("done_cyc_invalid", dcyc, 2);
        end
      end
    end
    chk("done_seen", dcnt, 1);
    chk("start_count", starts, n);
    step();
    chk("busy_after", oBusy, 0);
    chk("done_one_cycle", oDone, 0);
    if (n > 0) chk("best_hold", oBestCorr, ebest);
  endtask

  initial begin
    int cnt;
    int d2_cyc, d2_vc, d2_starts, d2_done_n, d2_idx;
    logic [CW-1:0] d2_exp [$];

    vt[0] = '{13'd0, 13'd1, 13'd0, 13'd1, 3};
    vt[1] = '{13'd2, 13'd4, 13'd5, 13'd6, 1};
    vt[2] = '{13'd7, 13'd7, 13'd7, 13'd7, 2};
    vt[3] = '{13'd10, 13'd4, 13'd0, 13'd0, 1};
    vt[4] = '{13'd0, 13'd0, 13'd5, 13'd3, 1};
    vt[5] = '{13'd8190, 13'd8191, 13'd8191, 13'd8191, 2};
    vt[6] = '{13'd0, 13'd2, 13'd0, 13'd0, 5};
    sc_tab[0] = '{24'd5, 24'd9, 24'd9, 24'd2, 24'd0, 24'd0, 24'd0, 24'd0};
    sc_tab[1] = '{24'd3, 24'd7, 24'd1, 24'd7, 24'd8, 24'd8, 24'd0, 24'd0};
    sc_tab[2] = '{24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
    sc_tab[3] = '{24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1};
    sc_tab[4] = '{24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1};
    sc_tab[5] = '{24'd1, 24'hFFFFFF, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};
    sc_tab[6] = '{24'd4, 24'd4, 24'd4, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0};

    iRST = 1'b1; iFrameDone = 1'b0; iAbort = 1'b0; iCorrValid = 1'b0; iCorrValue = '0;
    iXmin = '0; iXmax = '0; iYmin = '0; iYmax = '0;
    d2_fd = 1'b0; d2_abort = 1'b0; d2_valid = 1'b0; d2_value = '0;
    d2_xmin = '0; d2_xmax = '0; d2_ymin = '0; d2_ymax = '0;
    repeat (3) @(negedge iCLK);
    chk("rst_busy", oBusy, 0);
    chk("rst_start_done", {oCorrStart, oDone, oResultValid}, 0);
    chk("rst_xy", {oX, oY, oXresult, oYresult}, 0);
    chk("rst_best", oBestCorr, 0);
    iRST = 1'b0;

    run_vec(0);

    // Level held high must not start another search.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (oCorrStart || oBusy) cnt++;
    end
    chk("hold_no_retrigger", cnt, 0);

    for (int v = 1; v < 7; v++) run_vec(v);

    // Stride-2 instance: X 3..8 visits 3,5,7 then stops.
    for (int x = 3; x <= 8; x += 2) d2_exp.push_back(x[CW-1:0]);
    @(negedge iCLK);
    d2_xmin = 13'd3; d2_xmax = 13'd8; d2_ymin = 13'd0; d2_ymax = 13'd0;
    d2_fd = 1'b1;
    d2_cyc = 0; d2_vc = 0; d2_starts = 0; d2_done_n = 0; d2_idx = 0;
    while (d2_cyc < 200 && d2_done_n == 0) begin
      @(negedge iCLK);
      d2_cyc++;
      d2_valid = 1'b0;
      if (d2_vc > 0) begin
        d2_vc--;
        if (d2_vc == 0) begin
          d2_valid = 1'b1;
          d2_value = (d2_idx == 0) ? 24'd4 : 24'd6;
          d2_idx++;
        end
      end
      if (d2_start) begin
        d2_starts++;
        if (d2_exp.size() == 0) chk("s2_extra_start", 64'd1, 64'd0);
        else chk("s2_x", d2_x, d2_exp.pop_front());
        d2_vc = 1;
      end
      if (d2_done) begin
        d2_done_n++;
        chk("s2_result", {d2_rvalid, d2_xres, d2_yres, d2_best}, {1'b1, 13'd5, 13'd0, 24'd6});
      end
    end
    chk("s2_done_seen", d2_done_n, 1);
    chk("s2_starts", d2_starts, 3);

    // Abort together with a winning score: abort wins.
    kick(13'd0, 13'd3, 13'd0, 13'd0);
    wait_start("abort_s1");
    step(); step();
    iCorrValid = 1'b1; iCorrValue = 24'd5;
    wait_start("abort_s2");
    step(); step();
    iCorrValid = 1'b1; iCorrValue = 24'd100; iAbort = 1'b1;
    step();
    chk("abort_busy", oBusy, 0);
    chk("abort_rvalid", oResultValid, 0);
    chk("abort_best", oBestCorr, 5);
    chk("abort_xres", oXresult, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (oDone || oCorrStart) cnt++;
    end
    chk("abort_no_done", cnt, 0);

    // Abort in IDLE is harmless; next search still runs normally.
    iAbort = 1'b1;
    run_vec(2);

    // Reset during the second candidate.
    kick(13'd0, 13'd1, 13'd0, 13'd1);
    wait_start("rst_s1");
    step(); step();
    iCorrValid = 1'b1; iCorrValue = 24'd9;
    wait_start("rst_s2");
    chk("pre_rst_x", oX, 1);
    iRST = 1'b1; iFrameDone = 1'b0;
    step();
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_ctl", {oCorrStart, oDone, oResultValid}, 0);
    chk("mid_rst_xy", {oX, oY, oXresult, oYresult}, 0);
    chk("mid_rst_best", oBestCorr, 0);
    iRST = 1'b0;
    run_vec(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
